// File: rtl/popcount_arb_pkg.sv
// Shared types and helpers for the popcount arbiter and its shift-and-count engine.
package popcount_arb_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StResp = 2'd2
  } pca_state_e;

  // Bounds on the number of requesters the arbiter supports.
  localparam int unsigned PcaNreqMin = 2;
  localparam int unsigned PcaNreqMax = 16;

  // Smallest width able to index 'value' distinct codes (ceil(log2(value))).
  function automatic int unsigned clog2_w(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/popcount_engine.sv
// Shift-and-count population-count engine.
// 'load' captures an operand and clears the count; each 'step' adds the MSB of the shift
// register to the count and shifts left. 'zero' goes high once no ones remain, so trailing
// zeros are never shifted through.
module popcount_engine
  import popcount_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = clog2_w(DATA_W + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] operand,
  output logic [CNT_W-1:0]  count,
  output logic              zero
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Remaining ones are exhausted once the shift register is empty.
  always_comb begin
    zero = (shreg_q == '0);
  end

  // Next-state for the shift register and running count.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (load) begin
      shreg_d = operand;
      count_d = '0;
    end else if (step && !zero) begin
      // Count cannot wrap: at most DATA_W ones are ever added.
      count_d = count_q + CNT_W'(shreg_q[DATA_W-1]);
      shreg_d = shreg_q << 1;
    end
  end

  // Engine state registers with asynchronous clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count = count_q;
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Arbitrates NREQ operand sources onto one shared popcount engine and returns each result
// tagged with the owning requester index.
// Build option: define PCA_ROUND_ROBIN_EN for round-robin arbitration starting at a rotating
// pointer; otherwise the lowest-indexed valid requester always wins.
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = clog2_w(DATA_W + 1),
  parameter int unsigned IDW    = clog2_w(NREQ)
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [CNT_W-1:0]         rsp_count,
  input  logic                     rsp_ready,
  output logic                     busy
);

  pca_state_e state_q, state_d;
  logic [IDW-1:0] id_q, id_d;

  logic           any_valid;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;

  logic              eng_load;
  logic              eng_step;
  logic              eng_zero;
  logic [CNT_W-1:0]  eng_count;
  logic [DATA_W-1:0] operand;

`ifdef PCA_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pick: scan from rr_ptr upward with wrap; walking the offsets downward and
  // overwriting leaves the smallest offset (highest priority) as the final winner.
  always_comb begin
    any_valid = |req_valid;
    winner    = '0;
    cand      = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (req_valid[cand]) begin
        winner = cand;
      end
    end
  end
`else
  // Fixed priority: the lowest asserted index wins.
  always_comb begin
    any_valid = |req_valid;
    winner    = '0;
    cand      = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = IDW'(k);
      if (req_valid[cand]) begin
        winner = cand;
      end
    end
  end
`endif

  // Operand of the current winner, captured by the engine on the accept edge.
  always_comb begin
    operand = req_data[winner * DATA_W +: DATA_W];
  end

  // Grant is only offered while idle, so a response handshake always costs one bubble.
  always_comb begin
    if (state_q == StIdle && any_valid) begin
      req_ready = NREQ'(1) << winner;
    end else begin
      req_ready = '0;
    end
  end

  // Controller next-state and engine sequencing.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    eng_load = 1'b0;
    eng_step = 1'b0;
`ifdef PCA_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          eng_load = 1'b1;
          id_d     = winner;
          state_d  = StRun;
`ifdef PCA_ROUND_ROBIN_EN
          rr_ptr_d = IDW'((int'(winner) + 1) % int'(NREQ));
`endif
        end
      end
      StRun: begin
        if (eng_zero) begin
          state_d = StResp;
        end else begin
          eng_step = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller state, owner id and arbitration pointer.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= StIdle;
      id_q     <= '0;
`ifdef PCA_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
`ifdef PCA_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  popcount_engine #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_engine (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load    (eng_load),
    .step    (eng_step),
    .operand (operand),
    .count   (eng_count),
    .zero    (eng_zero)
  );

  // Response outputs; the engine holds its count untouched while in RESP.
  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_id    = id_q;
    rsp_count = eng_count;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_popcount_arbiter.sv
// Self-checking bench for popcount_arbiter: directed corner cases plus random traffic, with a
// cycle-level reference model predicting grants and response timing and a monitor comparing
// every presented response against a scoreboard queue.
module tb_popcount_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int IDW    = 2;

  logic                   ACLK = 1'b0;
  logic                   ARESETN;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [CNT_W-1:0]       rsp_count;
  logic                   rsp_ready;
  logic                   busy;

  popcount_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .IDW    (IDW)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mphase = 0;     // 0 idle, 1 computing, 2 response offered
  int   resp_start = 0;
  int   rr_model = 0;

`ifdef PCA_ROUND_ROBIN_EN
  localparam int NORDER = 5;
  int exp_order[NORDER] = '{0, 1, 2, 3, 0};
`else
  localparam int NORDER = 3;
  int exp_order[NORDER] = '{0, 0, 0};
`endif

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pop_of(input logic [DATA_W-1:0] v);
    int n = 0;
    for (int b = 0; b < DATA_W; b++) n += int'(v[b]);
    return n;
  endfunction

  // Shift cycles: DATA_W minus trailing zeros, or none for a zero operand.
  function automatic int shifts_of(input logic [DATA_W-1:0] v);
    int tz = 0;
    bit seen = 0;
    if (v == 0) return 0;
    for (int b = 0; b < DATA_W; b++) begin
      if (!seen && v[b]) seen = 1;
      if (!seen) tz++;
    end
    return DATA_W - tz;
  endfunction

  // First asserted requester at or after ptr, wrapping; ptr stays 0 for fixed priority.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 8'h80;
      3: return 8'h01;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // Reference model: predicts grants, busy and response timing every cycle.
  initial begin
    int w;
    int exp_ready;
    int nphase;
    logic [DATA_W-1:0] d;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        mphase = 0;
        rr_model = 0;
        sbq.delete();
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_count", int'(rsp_count), 0);
      end else begin
        exp_ready = 0;
        nphase = mphase;
        if (mphase == 0 && req_valid != 0) begin
          w = pick(req_valid, rr_model);
          exp_ready = 1 << w;
          d = req_data[w*DATA_W +: DATA_W];
          sbq.push_back('{w, pop_of(d)});
          resp_start = cyc + 2 + shifts_of(d);
          grant_log.push_back(onehot_idx(req_ready));
`ifdef PCA_ROUND_ROBIN_EN
          rr_model = (w + 1) % NREQ;
`endif
          nphase = 1;
        end else if (mphase == 1) begin
          if (cyc + 1 == resp_start) nphase = 2;
        end else if (mphase == 2) begin
          if (rsp_ready) nphase = 0;
        end
        check("req_ready", int'(req_ready), exp_ready);
        check("rsp_valid", int'(rsp_valid), int'(mphase == 2));
        check("busy", int'(busy), int'(mphase != 0));
        mphase = nphase;
      end
    end
  end

  // Monitor: every presented response must match the scoreboard head until it is taken.
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN && rsp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got id %0d count %0d, expected no response",
                   rsp_id, rsp_count);
        end else begin
          check("rsp_id", int'(rsp_id), sbq[0].id);
          check("rsp_count", int'(rsp_count), sbq[0].cnt);
          if (rsp_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  // mode 0: drop valid on accept; 1: keep valid with a fresh operand; 2: random traffic.
  task automatic step(input int mode);
    logic [NREQ-1:0] acc;
    @(negedge ACLK);
    acc = req_valid & req_ready;
    @(posedge ACLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        req_data[i*DATA_W +: DATA_W] = rand_operand();
        if (mode == 0) req_valid[i] = 1'b0;
        else if (mode == 2) req_valid[i] = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = rand_operand();
        end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (mode == 2) rsp_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic send(input int i, input logic [DATA_W-1:0] d);
    bit ok = 0;
    req_valid[i] = 1'b1;
    req_data[i*DATA_W +: DATA_W] = d;
    for (int n = 0; n < 100; n++) begin
      step(0);
      if (!req_valid[i]) begin
        ok = 1;
        break;
      end
    end
    check("send_accepted", int'(ok), 1);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    rsp_ready = 1'b1;
    for (int n = 0; n < bound; n++) begin
      if (req_valid == 0 && mphase == 0 && sbq.size() == 0) begin
        done = 1;
        break;
      end
      step(0);
    end
    if (req_valid == 0 && mphase == 0 && sbq.size() == 0) done = 1;
    check("drain_to_idle", int'(done), 1);
  endtask

  initial begin
    ARESETN   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Directed operands, including the full, empty and MSB-only corners.
    rsp_ready = 1'b1;
    send(2, 8'hB5);
    wait_idle(50);
    send(0, 8'hFF);
    wait_idle(50);
    send(1, 8'h00);
    wait_idle(50);
    send(3, 8'h80);
    wait_idle(50);

    // All requesters held valid: observe the grant order.
    grant_log.delete();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = rand_operand();
    for (int n = 0; n < 200 && grant_log.size() < NORDER; n++) step(1);
    req_valid = '0;
    wait_idle(100);
    check("order_len", int'(grant_log.size() >= NORDER), 1);
    for (int k = 0; k < NORDER && k < grant_log.size(); k++) check("grant_order", grant_log[k],
                                                                    exp_order[k]);

    // Backpressure with other requesters pending.
    rsp_ready = 1'b0;
    req_valid = 4'b1011;
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = rand_operand();
    repeat (25) step(0);
    wait_idle(200);

    // Reset while computing discards the operation.
    rsp_ready = 1'b1;
    send(3, 8'hF1);
    repeat (3) step(0);
    ARESETN = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_rsp_id", int'(rsp_id), 0);
    check("midrst_rsp_count", int'(rsp_count), 0);
    check("midrst_req_ready", int'(req_ready), 0);
    repeat (2) @(negedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (5) step(0);
    send(1, 8'h3C);
    wait_idle(50);

    // Random traffic with random backpressure.
    repeat (1500) step(2);
    wait_idle(500);
    check("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
